frame_mem_port: RTL and testbench
=================================

// Module: frame_mem_port
// PURPOSE
//  Memory-side responder for the triple-buffered frame store. Accepts word writes (current frame)
//  and word reads (reference frame) at byte addresses produced by the frame address generator,
//  arbitrates them onto one single-port memory bus (req/gnt) and returns read data in order.
//  Sits between the address generator / pixel pipeline and the external memory controller.
// PARAMETERS
//  FRAME_SIZE_BYTES  3_686_400  bytes per frame buffer; legal range = [0, 3*FRAME_SIZE_BYTES)
//  MAX_OUTSTANDING   4          max reads issued to memory but not yet returned (1..15)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous reset, active-high
//  wr_valid     in   1   write request valid
//  wr_ready     out  1   write request accepted this cycle (combinational)
//  wr_addr      in   32  write byte address
//  wr_data      in   32  write data word
//  rd_valid     in   1   read request valid
//  rd_ready     out  1   read request accepted this cycle (combinational)
//  rd_addr      in   32  read byte address
//  rd_data_valid out 1   read data return pulse (registered)
//  rd_data      out  32  read data, meaningful only when rd_data_valid=1
//  mem_req      out  1   memory command valid; held until mem_gnt
//  mem_we       out  1   1=write, 0=read; stable while mem_req=1
//  mem_addr     out  32  memory byte address; stable while mem_req=1
//  mem_wdata    out  32  memory write data; stable while mem_req=1
//  mem_gnt      in   1   memory accepted command this cycle (ignored when mem_req=0)
//  mem_rvalid   in   1   memory read data valid, in issue order, no backpressure
//  mem_rdata    in   32  memory read data
//  addr_err     out  1   sticky: an accepted address was misaligned (addr[1:0]!=0) or out of range
// BEHAVIOUR
//  Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data_valid=0, rd_data=0,
//   addr_err=0, outstanding=0, last_grant=READ (so first contention goes to WRITE).
//  FSM IDLE: pick source; wr_ready/rd_ready asserted in IDLE only, at most one per cycle.
//   rd eligible only if rd_valid && outstanding<MAX_OUTSTANDING; wr eligible if wr_valid.
//   Both eligible: grant the one not equal to last_grant (round-robin); update last_grant.
//   On grant: latch addr/data/we into command regs, go ISSUE. Nothing eligible: stay IDLE.
//  FSM ISSUE: mem_req=1 with latched command; on mem_gnt=1 return to IDLE next cycle;
//   read grant increments outstanding at the mem_gnt cycle.
//  Throughput: one command per 2 cycles max (accept cycle N, mem_req cycle N+1, gnt same cycle).
//  Write latency: wr_ready at N -> mem_req/mem_we=1 at N+1.
//  Read return: mem_rvalid at cycle M -> rd_data_valid=1, rd_data=mem_rdata at M+1, one-cycle pulse.
//  outstanding: +1 on read mem_gnt, -1 on mem_rvalid; both same cycle -> unchanged.
//   mem_rvalid with outstanding=0 is a protocol error: ignored for counting (no underflow),
//   data still forwarded.
//  Address check on accepted request: addr[1:0]!=0 or addr>=3*FRAME_SIZE_BYTES -> addr_err<=1
//   (sticky until rst); request still issued unchanged so ordering is preserved.
//  Address wrap-around within buffers is the generator's job; no modification here.
//  Reset mid-operation: all state cleared asynchronously; in-flight memory reads are forgotten,
//   late mem_rvalid after reset forwards data but does not decrement below 0.
//  Arithmetic: range compare done at 32 bits unsigned; outstanding is 4 bits.
// TESTING
//  1. wr_valid=1, wr_addr=0x0000_0010, wr_data=0xDEAD_BEEF, mem_gnt=1 -> wr_ready at N,
//     mem_req=1 mem_we=1 mem_addr=0x10 mem_wdata=0xDEADBEEF at N+1, IDLE at N+2.
//  2. wr_valid & rd_valid both held 1, mem_gnt=1 -> grants alternate W,R,W,R from reset.
//  3. mem_gnt=0 for 5 cycles in ISSUE -> mem_req/addr/we/wdata stable, no ready asserted.
//  4. 4 reads granted, no mem_rvalid -> rd_ready stays 0 while rd_valid=1; one mem_rvalid
//     (rdata=0x1234) -> rd_data_valid=1 rd_data=0x1234 next cycle, 5th read accepted.
//  5. wr_addr=0x0000_0002 then rd_addr=0x00A8_C000 (=3*FRAME_SIZE_BYTES) -> addr_err=1 after
//     first accept, both still issued, stays 1 until rst.
//  6. rst pulsed while in ISSUE with 2 reads outstanding -> all outputs reset values
//     immediately; subsequent mem_rvalid leaves outstanding at 0.

Source files
------------

// File: rtl/frame_mem_port.sv
// rtl/frame_mem_port.sv - frame store memory port: round-robin read/write arbitration onto a req/gnt bus
// Returns read data in issue order and flags misaligned or out-of-range addresses.
module frame_mem_port #(
    parameter int FRAME_SIZE_BYTES = 3_686_400,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [31:0] rd_addr,
    output logic        rd_data_valid,
    output logic [31:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        addr_err
);

    localparam logic [31:0] ADDR_LIMIT = 32'(3 * FRAME_SIZE_BYTES);
    localparam logic [3:0]  MAX_OUT    = 4'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant_rd;
    logic [3:0]  outstanding;
    logic        rd_elig;
    logic        wr_elig;
    logic        grant_wr;
    logic        grant_rd;
    logic        accept;
    logic [31:0] acc_addr;
    logic        acc_bad;
    logic        cnt_inc;
    logic        cnt_dec;

    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        rd_elig   = rd_valid && (outstanding < MAX_OUT);
        wr_elig   = wr_valid;
        case (state)
            IDLE: begin
                // On contention the source that did not win last time gets the bus.
                if (wr_elig && rd_elig) begin
                    if (last_grant_rd) begin
                        grant_wr = 1'b1;
                    end else begin
                        grant_rd = 1'b1;
                    end
                end else if (wr_elig) begin
                    grant_wr = 1'b1;
                end else if (rd_elig) begin
                    grant_rd = 1'b1;
                end
                if (grant_wr || grant_rd) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_ready = grant_wr;
    assign rd_ready = grant_rd;
    assign mem_req  = (state == ISSUE);
    assign accept   = grant_wr || grant_rd;
    assign acc_addr = grant_wr ? wr_addr : rd_addr;
    assign acc_bad  = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);

    // A late return with nothing outstanding (e.g. after reset) must not underflow the count.
    assign cnt_inc  = mem_req && mem_gnt && !mem_we;
    assign cnt_dec  = mem_rvalid && (outstanding != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant_rd <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            addr_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant_rd <= grant_rd;
                mem_we        <= grant_wr;
                mem_addr      <= acc_addr;
                mem_wdata     <= grant_wr ? wr_data : 32'd0;
                if (acc_bad) begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= 4'd0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_valid <= 1'b0;
            rd_data       <= 32'd0;
        end else begin
            rd_data_valid <= mem_rvalid;
            if (mem_rvalid) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_frame_mem_port.sv
// tb/tb_frame_mem_port.sv - scoreboard bench for frame_mem_port
// Expected memory commands and read returns are queued at stimulus time and checked by a monitor.
module tb_frame_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [31:0] rd_addr = '0;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        addr_err;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd[$];
    int          n_checks = 0;
    int          n_fail = 0;

    frame_mem_port dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (mem_req && mem_gnt) begin
            if (exp_cmd.size() == 0) begin
                timeout_fail("unexpected_mem_cmd");
            end else begin
                cmd_t c;
                c = exp_cmd.pop_front();
                check("sb_mem_we", 32'(mem_we), 32'(c.we));
                check("sb_mem_addr", mem_addr, c.addr);
                if (c.we) check("sb_mem_wdata", mem_wdata, c.wdata);
            end
        end
        if (rd_data_valid) begin
            if (exp_rd.size() == 0) begin
                timeout_fail("unexpected_rd_data");
            end else begin
                logic [31:0] d;
                d = exp_rd.pop_front();
                check("sb_rd_data", rd_data, d);
            end
        end
    end

    // Entry phase for all tasks: #1 after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bit ok = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_ready) begin ok = 1; break; end
        end
        if (ok) exp_cmd.push_back('{we: 1'b1, addr: a, wdata: d});
        else timeout_fail("write_accept");
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        bit ok = 0;
        rd_valid = 1'b1; rd_addr = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_ready) begin ok = 1; break; end
        end
        if (ok) exp_cmd.push_back('{we: 1'b0, addr: a, wdata: 32'd0});
        else timeout_fail("read_accept");
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic return_data(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
        exp_rd.push_back(d);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wr_valid = 1'b0; rd_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_cmd.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit exp_w;
        int cnt;

        // Reset state
        #2;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rd_data_valid", 32'(rd_data_valid), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_addr_err", 32'(addr_err), 0);

        // Contention from reset: W,R,W,R
        do_reset();
        mem_gnt = 1'b1;
        wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 32'hA5A5_0001;
        rd_valid = 1'b1; rd_addr = 32'h200;
        exp_w = 1; cnt = 0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge clk);
            if (wr_ready || rd_ready) begin
                check("alt_grant", 32'({wr_ready, rd_ready}), exp_w ? 32'd2 : 32'd1);
                exp_cmd.push_back('{we: exp_w, addr: exp_w ? 32'h100 : 32'h200,
                                    wdata: exp_w ? 32'hA5A5_0001 : 32'd0});
                exp_w = !exp_w;
                cnt++;
            end
        end
        if (cnt != 4) timeout_fail("alt_grant_count");
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        return_data(32'h0000_AAAA);
        return_data(32'h0000_BBBB);

        // Single write latency
        do_reset();
        mem_gnt = 1'b1;
        do_write(32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_mem_req", 32'(mem_req), 1);
        check("t1_mem_we", 32'(mem_we), 1);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_idle", 32'(mem_req), 0);

        // Stall in ISSUE
        do_reset();
        mem_gnt = 1'b0;
        do_write(32'h80, 32'h1357_9BDF);
        rd_valid = 1'b1; rd_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_mem_req", 32'(mem_req), 1);
            check("t3_mem_we", 32'(mem_we), 1);
            check("t3_mem_addr", mem_addr, 32'h80);
            check("t3_mem_wdata", mem_wdata, 32'h1357_9BDF);
            check("t3_no_ready", 32'({wr_ready, rd_ready}), 0);
        end
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        do_read(32'h40);
        return_data(32'h4040_4040);

        // Outstanding limit
        do_reset();
        mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) do_read(32'(k * 4));
        rd_valid = 1'b1; rd_addr = 32'h20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_rd_blocked", 32'(rd_ready), 0);
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        exp_rd.push_back(32'h1234);
        @(negedge clk);
        check("t4_still_blocked", 32'(rd_ready), 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("t4_rdv", 32'(rd_data_valid), 1);
        check("t4_rd_data", rd_data, 32'h1234);
        check("t4_fifth_ready", 32'(rd_ready), 1);
        if (rd_ready) exp_cmd.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'd0});
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        check("t4_rdv_pulse", 32'(rd_data_valid), 0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) return_data(32'h5000 + 32'(k));

        // Address checks
        do_reset();
        mem_gnt = 1'b1;
        do_read(32'h00A8_BFFC);
        @(negedge clk);
        check("t5_last_legal", 32'(addr_err), 0);
        @(posedge clk); #1;
        do_read(32'h00A8_C000);
        @(negedge clk);
        check("t5_range", 32'(addr_err), 1);
        do_reset();
        mem_gnt = 1'b1;
        do_write(32'h2, 32'h0BAD_0002);
        @(negedge clk);
        check("t5_misaligned", 32'(addr_err), 1);
        @(posedge clk); #1;
        do_read(32'h00A8_C000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5_sticky", 32'(addr_err), 1);

        // Reset mid-operation
        do_reset();
        check("t6_err_cleared", 32'(addr_err), 0);
        mem_gnt = 1'b1;
        do_read(32'h300);
        do_read(32'h304);
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        do_read(32'h308);
        @(negedge clk);
        check("t6_in_issue", 32'(mem_req), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_mem_req", 32'(mem_req), 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_we", 32'(mem_we), 0);
        check("t6_rdv", 32'(rd_data_valid), 0);
        exp_cmd.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return_data(32'h0000_CAFE);
        mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) do_read(32'h400 + 32'(k * 4));
        rd_valid = 1'b1; rd_addr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_limit_after_late", 32'(rd_ready), 0);
        end
        @(posedge clk); #1;
        rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("end_cmd_queue_empty", 32'(exp_cmd.size()), 0);
        check("end_rd_queue_empty", 32'(exp_rd.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
